// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit: multi-cycle unsigned multiply / divide engine.
// One bit is resolved per clock: shift-add multiply (multiplier LSB first)
// or restoring division (dividend MSB first). Results are registered in FIN
// and announced with a one-cycle done pulse.
module seq_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALU_OP,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Result2,
  output logic             div_by_zero,
  output logic             op_err
);

  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam int         CW     = $clog2(WIDTH) + 1;
  localparam int         RW     = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t               state_reg;
  state_t               state_next;

  logic [CW-1:0]        count_reg;
  logic [3:0]           op_reg;
  logic [WIDTH-1:0]     mcand_reg;     // latched X, added in on each set multiplier bit
  logic [WIDTH-1:0]     divisor_reg;   // latched Y
  logic [2*WIDTH-1:0]   prod_reg;      // {partial sum, remaining multiplier bits}
  logic [WIDTH:0]       rem_reg;       // partial remainder
  logic [WIDTH-1:0]     quo_reg;       // dividend bits shift out, quotient bits shift in

  logic                 last_iter;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH+1:0]     div_shift;
  logic                 div_ge;
  logic [WIDTH:0]       rem_next;

  assign last_iter = (count_reg == CW'(WIDTH - 1));
  assign busy      = (state_reg != IDLE);

  // Per-iteration datapath: one multiply step and one restoring-divide step
  always_comb begin
    mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
              + (prod_reg[0] ? {1'b0, mcand_reg} : {RW{1'b0}});
    div_shift = {rem_reg, quo_reg[WIDTH-1]};
    div_ge    = (div_shift >= {2'b00, divisor_reg});
    rem_next  = div_ge ? RW'(div_shift - {2'b00, divisor_reg}) : div_shift[WIDTH:0];
  end

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: dispatch on the op code at acceptance, count iterations
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          case (ALU_OP)
            OP_MUL:  state_next = MUL;
            OP_DIV:  state_next = DIV;
            default: state_next = FIN;
          endcase
        end
      end
      MUL:     if (last_iter) state_next = FIN;
      DIV:     if (last_iter) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, iteration registers and result/flag registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_reg   <= '0;
      op_reg      <= '0;
      mcand_reg   <= '0;
      divisor_reg <= '0;
      prod_reg    <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      done        <= 1'b0;
      Result      <= '0;
      Result2     <= '0;
      div_by_zero <= 1'b0;
      op_err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg      <= ALU_OP;
            mcand_reg   <= X;
            divisor_reg <= Y;
            count_reg   <= '0;
            prod_reg    <= {{WIDTH{1'b0}}, Y};
            rem_reg     <= '0;
            quo_reg     <= X;
          end
        end
        MUL: begin
          prod_reg  <= {mul_sum, prod_reg[WIDTH-1:1]};
          count_reg <= count_reg + 1'b1;
        end
        DIV: begin
          rem_reg   <= rem_next;
          quo_reg   <= {quo_reg[WIDTH-2:0], div_ge};
          count_reg <= count_reg + 1'b1;
        end
        FIN: begin
          done <= 1'b1;
          case (op_reg)
            OP_MUL: begin
              Result      <= prod_reg[WIDTH-1:0];
              Result2     <= prod_reg[2*WIDTH-1:WIDTH];
              div_by_zero <= 1'b0;
              op_err      <= 1'b0;
            end
            OP_DIV: begin
              // A zero divisor needs no special path: every trial subtract
              // succeeds, giving an all-ones quotient and remainder = X.
              Result      <= quo_reg;
              Result2     <= rem_reg[WIDTH-1:0];
              div_by_zero <= (divisor_reg == '0);
              op_err      <= 1'b0;
            end
            default: begin
              Result      <= '0;
              Result2     <= '0;
              div_by_zero <= 1'b0;
              op_err      <= 1'b1;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
